// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with restoring radix-2 division
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t state, next;
    logic [2:0]        opq;
    logic [XLEN-1:0]   a, b, quo, dvs;
    logic [XLEN:0]     rem, dif;
    logic [XLEN+1:0]   sh;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] ea, eb, prod;
    logic              sgn, dz, ovf, s1, s2, ge;
    logic [XLEN-1:0]   abs1, abs2, mulres, qf, rf;

    assign sgn  = ~op[0];
    assign dz   = data2 == '0;
    assign ovf  = sgn && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (&data2);
    assign abs1 = (sgn && data1[XLEN-1]) ? -data1 : data1;
    assign abs2 = (sgn && data2[XLEN-1]) ? -data2 : data2;
    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed
    assign s1     = ^opq[1:0];
    assign s2     = opq[1:0] == 2'b01;
    assign ea     = {{XLEN{s1 & a[XLEN-1]}}, a};
    assign eb     = {{XLEN{s2 & b[XLEN-1]}}, b};
    assign prod   = ea * eb;
    assign mulres = (opq[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign sh     = {rem, quo[XLEN-1]};
    assign ge     = sh >= {2'b00, dvs};
    assign dif    = sh[XLEN:0] - {1'b0, dvs};
    assign qf     = (~opq[0] && (a[XLEN-1] ^ b[XLEN-1])) ? -quo : quo;
    assign rf     = (~opq[0] && a[XLEN-1]) ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = !op[2] ? MUL : (dz || ovf) ? DONE : DIV;
            MUL:     next = DONE;
            DIV:     if (cnt == CNT_W'(1)) next = FIX;
            FIX:     next = DONE;
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opq    <= '0;
            a      <= '0;
            b      <= '0;
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start && !flush) begin
                    opq <= op;
                    a   <= data1;
                    b   <= data2;
                    rem <= '0;
                    quo <= abs1;
                    dvs <= abs2;
                    cnt <= CNT_W'(XLEN);
                    if (op[2] && (dz || ovf))
                        result <= op[1] ? (dz ? data1 : '0) : (dz ? '1 : data1);
                end
                MUL: if (!flush) result <= mulres;
                DIV: begin
                    rem <= ge ? dif : sh[XLEN:0];
                    quo <= {quo[XLEN-2:0], ge};
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: if (!flush) result <= opq[1] ? rf : qf;
                default: ;
            endcase
        end
    end
endmodule
